// File: rtl/cpu_io_bridge.sv
// Host-side bridge for the CPU's 16-bit I/O word pair: a held input word fed from a
// valid/ready stream, and a change-capture FIFO on the CPU output word.
module cpu_io_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int HOLD  = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] cpu_in_word,
    input  logic [WIDTH-1:0] cpu_out_word,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [7:0]    HOLD_LOAD = 8'(HOLD);

    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] cpu_in_q, cpu_in_d;
    logic [WIDTH-1:0] out_last_q, out_last_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic accept, push, pop, full, wr_en;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        cpu_in_d   = cpu_in_q;
        out_last_d = cpu_out_word;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        accept = host_in_valid && (hold_cnt_q == 8'd0);
        if (accept) begin
            cpu_in_d   = host_in_data;
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != 8'd0) begin
            hold_cnt_d = hold_cnt_q - 8'd1;
        end

        // A full FIFO still takes a push when the head leaves in the same cycle.
        push  = (cpu_out_word != out_last_q);
        pop   = (count_q != '0) && host_out_ready;
        full  = (count_q == CNT_FULL);
        wr_en = push && (!full || pop);

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_en && !pop)      count_d = count_q + CNT_ONE;
        else if (!wr_en && pop) count_d = count_q - CNT_ONE;
        if (push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= 8'd0;
            cpu_in_q   <= '0;
            out_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            cpu_in_q   <= cpu_in_d;
            out_last_q <= out_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; entries are only visible through count_q, and the head must
    // be readable in the cycle it is written, so the read port is asynchronous.
    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= cpu_out_word;
    end

    assign host_in_ready  = (hold_cnt_q == 8'd0);
    assign cpu_in_word    = cpu_in_q;
    assign host_out_valid = (count_q != '0);
    assign host_out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign out_count      = count_q;
    assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed and randomized checks of cpu_io_bridge against a queue-based reference that
// tracks input acceptance by absolute edge numbers.
module tb_cpu_io_bridge;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [WIDTH-1:0] cpu_in_word;
    logic [WIDTH-1:0] cpu_out_word;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    always #5 CLK = ~CLK;

    cpu_io_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .CLK(CLK), .reset(reset),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .cpu_in_word(cpu_in_word), .cpu_out_word(cpu_out_word),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready), .out_count(out_count), .out_overflow(out_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: the next edge number at which an input word may be taken.
    logic [WIDTH-1:0] m_cpu_in;
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    int               edge_no = 0;
    int               next_ok = 0;

    bit obs_ready;
    int dut_acc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cpu_in = '0;
        m_last   = '0;
        m_q.delete();
        m_ovf    = 1'b0;
        next_ok  = 0;
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        chk("in_ready", host_in_ready, (edge_no + 1) >= next_ok);
        chk("cpu_in_word", cpu_in_word, m_cpu_in);
        chk("out_valid", host_out_valid, m_q.size() != 0);
        chk("out_data", host_out_data, head);
        chk("out_count", out_count, m_q.size());
        chk("out_overflow", out_overflow, m_ovf);
        obs_ready = host_in_ready;
        if (host_in_ready && host_in_valid) dut_acc.push_back(edge_no + 1);
    endtask

    task automatic model_step();
        int e;
        e = edge_no + 1;
        if (host_in_valid && e >= next_ok) begin
            m_cpu_in = host_in_data;
            next_ok  = e + HOLD + 1;
        end
        if (m_q.size() != 0 && host_out_ready) void'(m_q.pop_front());
        if (cpu_out_word != m_last) begin
            if (m_q.size() < DEPTH) m_q.push_back(cpu_out_word);
            else m_ovf = 1'b1;
        end
        m_last = cpu_out_word;
    endtask

    task automatic cycle();
        @(negedge CLK);
        check_outputs();
        if (reset) model_reset();
        else model_step();
        @(posedge CLK);
        edge_no++;
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp3 [3];
        int low_cnt;

        // Reset with every input driven non-zero
        reset = 1'b1;
        host_in_data = 16'hFFFF; host_in_valid = 1'b1;
        cpu_out_word = 16'h1357; host_out_ready = 1'b1;
        model_reset();
        cycle(); cycle();
        chk("rst_cpu_in", cpu_in_word, 0);
        chk("rst_in_ready", host_in_ready, 1);
        chk("rst_out_valid", host_out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_overflow", out_overflow, 0);
        host_in_valid = 1'b0; host_in_data = '0; cpu_out_word = '0; host_out_ready = 1'b0;
        #1 reset = 1'b0;
        cycle();

        // Input hold: two words offered back to back
        dut_acc.delete();
        low_cnt = 0;
        host_in_valid = 1'b1; host_in_data = 16'h1234;
        for (int i = 0; i < 20 && dut_acc.size() < 2; i++) begin
            cycle();
            if (dut_acc.size() == 1) begin
                host_in_data = 16'hABCD;
                if (!obs_ready) low_cnt++;
            end
        end
        host_in_valid = 1'b0;
        chk("hold_two_accepts", dut_acc.size(), 2);
        if (dut_acc.size() == 2) chk("hold_accept_gap", dut_acc[1] - dut_acc[0], HOLD + 1);
        chk("hold_ready_low", low_cnt, HOLD);
        chk("hold_word", cpu_in_word, 16'hABCD);
        for (int i = 0; i < HOLD + 1; i++) cycle();

        // Change detector: 0,5,5,7,5 without popping
        host_out_ready = 1'b0;
        begin
            logic [WIDTH-1:0] seq [5];
            seq = '{16'h0000, 16'h0005, 16'h0005, 16'h0007, 16'h0005};
            for (int i = 0; i < 5; i++) begin
                cpu_out_word = seq[i];
                cycle();
            end
        end
        chk("chg_count", out_count, 3);
        exp3 = '{16'h0005, 16'h0007, 16'h0005};
        host_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("chg_drain", host_out_data, exp3[i]);
            cycle();
        end
        chk("chg_empty", host_out_valid, 0);

        // Full FIFO with a pop in the same cycle as a new change
        host_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cpu_out_word = 16'h0100 + 16'(i);
            cycle();
        end
        chk("fullpop_count_pre", out_count, 4);
        host_out_ready = 1'b1;
        cpu_out_word = 16'h0105;
        cycle();
        chk("fullpop_count", out_count, 4);
        chk("fullpop_overflow", out_overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            chk("fullpop_drain", host_out_data, 16'h0100 + 16'(i));
            cycle();
        end
        chk("fullpop_empty", host_out_valid, 0);

        // Overflow: five distinct changes, no pops
        host_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cpu_out_word = 16'(i * 16'h11);
            cycle();
        end
        chk("ovf_count", out_count, 4);
        chk("ovf_flag", out_overflow, 1);
        host_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", host_out_data, 16'(i * 16'h11));
            cycle();
        end
        chk("ovf_fifth_absent", host_out_valid, 0);
        chk("ovf_data_zero", host_out_data, 0);

        // Reset mid-hold with two words queued
        host_out_ready = 1'b0;
        host_in_valid = 1'b1; host_in_data = 16'h0BEE; cpu_out_word = 16'h00A1;
        cycle();
        host_in_valid = 1'b0; cpu_out_word = 16'h00A2;
        cycle();
        cycle();
        chk("mid_ready_pre", host_in_ready, 0);
        chk("mid_count_pre", out_count, 2);
        cpu_out_word = 16'h00FF;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_ready", host_in_ready, 1);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_valid", host_out_valid, 0);
        chk("mid_rst_data", host_out_data, 0);
        chk("mid_rst_cpu_in", cpu_in_word, 0);
        chk("mid_rst_overflow", out_overflow, 0);
        model_reset();
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("mid_single_push", out_count, 1);
        chk("mid_push_data", host_out_data, 16'h00FF);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            host_in_valid  = 1'($urandom_range(0, 1));
            host_in_data   = 16'($urandom);
            host_out_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) cpu_out_word = 16'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
